// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers functional-unit results per source and broadcasts one per cycle on the CDB, round-robin.
module cdb_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_IDX_WIDTH = 5
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic [NUM_SRC-1:0]                      src_valid,
    output logic [NUM_SRC-1:0]                      src_ready,
    input  logic [NUM_SRC-1:0][ROB_IDX_WIDTH-1:0]   src_rob_idx,
    input  logic [NUM_SRC-1:0][4:0]                 src_rd_addr,
    input  logic [NUM_SRC-1:0][31:0]                src_data,
    input  logic [NUM_SRC-1:0]                      src_regf_we,
    output logic                                    cdb_valid,
    output logic [$clog2(NUM_SRC)-1:0]              cdb_src,
    output logic [ROB_IDX_WIDTH-1:0]                cdb_rob_idx,
    output logic [4:0]                              cdb_rd_addr,
    output logic [31:0]                             cdb_data,
    output logic                                    cdb_regf_we
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = ROB_IDX_WIDTH + 38;
    logic [EW-1:0] mem [NUM_SRC][FIFO_DEPTH];
    logic [PW-1:0] head [NUM_SRC];
    logic [PW-1:0] tail [NUM_SRC];
    logic [CW-1:0] count [NUM_SRC];
    logic [SW-1:0] rr_ptr, win;
    logic found;
    logic [EW-1:0] win_e;
    logic [NUM_SRC-1:0] push, pop;
    // first non-empty FIFO scanning upward from rr_ptr
    always_comb begin
        found = 1'b0;
        win = rr_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && count[SW'((int'(rr_ptr) + k) % NUM_SRC)] != '0) begin
                found = 1'b1;
                win = SW'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
        win_e = mem[win][head[win]];
        for (int k = 0; k < NUM_SRC; k++) begin
            src_ready[k] = count[k] < CW'(FIFO_DEPTH);
            push[k] = !flush && src_valid[k] && src_ready[k];
            pop[k] = !flush && found && win == SW'(k);
        end
    end
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (rst || flush) begin
                head[k] <= '0;
                tail[k] <= '0;
                count[k] <= '0;
            end else begin
                if (push[k]) begin
                    mem[k][tail[k]] <= {src_rob_idx[k], src_rd_addr[k], src_data[k], src_regf_we[k]};
                    tail[k] <= tail[k] + 1'b1;
                end
                if (pop[k]) head[k] <= head[k] + 1'b1;
                count[k] <= count[k] + CW'(push[k]) - CW'(pop[k]);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_src <= '0;
            cdb_rob_idx <= '0;
            cdb_rd_addr <= '0;
            cdb_data <= '0;
            cdb_regf_we <= 1'b0;
            rr_ptr <= '0;
        end else if (flush || !found) begin
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= 1'b1;
            cdb_src <= win;
            cdb_rob_idx <= win_e[EW-1 -: ROB_IDX_WIDTH];
            cdb_rd_addr <= win_e[37:33];
            cdb_data <= win_e[32:1];
            cdb_regf_we <= win_e[0] && win_e[37:33] != 5'd0;
            rr_ptr <= (win == SW'(NUM_SRC - 1)) ? '0 : win + 1'b1;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of CDB arbitration, flush, x0 handling and reset.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst, flush;
    logic [1:0] src_valid, src_ready, src_regf_we;
    logic [1:0][4:0] src_rob_idx, src_rd_addr;
    logic [1:0][31:0] src_data;
    logic cdb_valid, cdb_regf_we;
    logic [0:0] cdb_src;
    logic [4:0] cdb_rob_idx, cdb_rd_addr;
    logic [31:0] cdb_data;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready), .src_rob_idx(src_rob_idx),
        .src_rd_addr(src_rd_addr), .src_data(src_data), .src_regf_we(src_regf_we),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_idx(cdb_rob_idx),
        .cdb_rd_addr(cdb_rd_addr), .cdb_data(cdb_data), .cdb_regf_we(cdb_regf_we)
    );
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input int s, input logic [4:0] rob, input logic [4:0] rd, input logic [31:0] d, input logic we);
        src_valid[s] = 1'b1;
        src_rob_idx[s] = rob;
        src_rd_addr[s] = rd;
        src_data[s] = d;
        src_regf_we[s] = we;
    endtask
    logic [4:0] q0 [$];
    logic [4:0] q1 [$];
    initial begin
        logic [1:0] acc;
        logic exp_src;
        int n0, n1, nb;
        rst = 1'b1; flush = 1'b0; src_valid = '0; src_rob_idx = '0;
        src_rd_addr = '0; src_data = '0; src_regf_we = '0;
        tick();
        rst = 1'b0;
        check("rst_valid", cdb_valid, 0);
        check("rst_data", cdb_data, 0);
        check("rst_rob", cdb_rob_idx, 0);
        check("rst_we", cdb_regf_we, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", cdb_valid, 0);
            check("idle_ready", src_ready, 2'b11);
        end
        // single ALU result
        drive(0, 5'd3, 5'd5, 32'hDEADBEEF, 1'b1);
        tick();
        src_valid = '0;
        check("single_t", cdb_valid, 0);
        tick();
        check("single_valid", cdb_valid, 1);
        check("single_src", cdb_src, 0);
        check("single_rob", cdb_rob_idx, 3);
        check("single_rd", cdb_rd_addr, 5);
        check("single_data", cdb_data, 32'hDEADBEEF);
        check("single_we", cdb_regf_we, 1);
        tick();
        check("single_pulse", cdb_valid, 0);
        check("single_hold", cdb_data, 32'hDEADBEEF);
        // full contention; rr_ptr is 1 here, so broadcasts alternate starting at src 1
        n0 = 0; n1 = 0; nb = 0; exp_src = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                drive(0, 5'(10 + n0), 5'd1, 32'(10 + n0), 1'b1);
                drive(1, 5'(20 + n1), 5'd2, 32'(20 + n1), 1'b1);
            end else src_valid = '0;
            if (c == 2) check("contend_ready", src_ready, 2'b10);
            acc = src_valid & src_ready;
            tick();
            if (acc[0]) begin q0.push_back(5'(10 + n0)); n0++; end
            if (acc[1]) begin q1.push_back(5'(20 + n1)); n1++; end
            if (c == 0) check("contend_first", cdb_valid, 0);
            if (cdb_valid) begin
                nb++;
                check("contend_src", cdb_src, exp_src);
                exp_src = ~exp_src;
                if (cdb_src == 1'b0 && q0.size() > 0) check("contend_rob0", cdb_rob_idx, q0.pop_front());
                else if (cdb_src == 1'b1 && q1.size() > 0) check("contend_rob1", cdb_rob_idx, q1.pop_front());
                else check("contend_dup", 1, 0);
            end
        end
        check("contend_count", nb, 10);
        check("contend_left", q0.size() + q1.size(), 0);
        // mul source alone, back-to-back
        drive(1, 5'd7, 5'd3, 32'd7, 1'b1);
        tick();
        check("mul_lat", cdb_valid, 0);
        drive(1, 5'd8, 5'd3, 32'd8, 1'b1);
        tick();
        check("mul_v7", cdb_valid, 1);
        check("mul_s7", cdb_src, 1);
        check("mul_r7", cdb_rob_idx, 7);
        drive(1, 5'd9, 5'd3, 32'd9, 1'b1);
        tick();
        check("mul_v8", cdb_valid, 1);
        check("mul_r8", cdb_rob_idx, 8);
        src_valid = '0;
        tick();
        check("mul_v9", cdb_valid, 1);
        check("mul_s9", cdb_src, 1);
        check("mul_r9", cdb_rob_idx, 9);
        tick();
        check("mul_end", cdb_valid, 0);
        // fill and flush together with a new push
        drive(0, 5'd16, 5'd4, 32'd16, 1'b1);
        drive(1, 5'd24, 5'd4, 32'd24, 1'b1);
        tick();
        drive(0, 5'd17, 5'd4, 32'd17, 1'b1);
        drive(1, 5'd25, 5'd4, 32'd25, 1'b1);
        tick();
        check("fill_valid", cdb_valid, 1);
        check("fill_rob", cdb_rob_idx, 16);
        check("fill_ready", src_ready, 2'b01);
        src_valid = 2'b01;
        drive(0, 5'd18, 5'd4, 32'd18, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        src_valid = '0;
        check("flush_valid", cdb_valid, 0);
        check("flush_ready", src_ready, 2'b11);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("flush_stale", cdb_valid, 0);
        end
        // x0 destination
        drive(0, 5'd12, 5'd0, 32'h1234, 1'b1);
        tick();
        src_valid = '0;
        tick();
        check("x0_valid", cdb_valid, 1);
        check("x0_we", cdb_regf_we, 0);
        check("x0_data", cdb_data, 32'h1234);
        check("x0_rd", cdb_rd_addr, 0);
        // reset mid-stream
        drive(0, 5'd13, 5'd6, 32'd13, 1'b1);
        drive(1, 5'd15, 5'd6, 32'd15, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_valid = '0;
        check("rst2_valid", cdb_valid, 0);
        check("rst2_data", cdb_data, 0);
        check("rst2_rob", cdb_rob_idx, 0);
        check("rst2_src", cdb_src, 0);
        check("rst2_ready", src_ready, 2'b11);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst2_empty", cdb_valid, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
